// File: rtl/dt_bias_feeder.sv
// dt/bias tile feeder: buffers dt tiles from DMA in a small FIFO and issues
// one dt tile plus its matching bias tile per cycle, walking NT tiles per token
// for seq_len tokens.
// Optional statistics counters are enabled by defining DT_FEED_STATS_EN.
module dt_bias_feeder #(
  parameter int unsigned DW         = 16,
  parameter int unsigned H_TILE     = 1,
  parameter int unsigned NH         = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned NT        = NH / H_TILE,
  localparam int unsigned AW        = (NT > 1) ? $clog2(NT) : 1,
  localparam int unsigned TW        = H_TILE * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [15:0]   seq_len_i,
  input  logic          bias_we_i,
  input  logic [AW-1:0] bias_addr_i,
  input  logic [TW-1:0] bias_wdata_i,
  input  logic          dt_valid_i,
  output logic          dt_ready_o,
  input  logic [TW-1:0] dt_data_i,
  input  logic          hold_i,
  output logic          valid_o,
  output logic [TW-1:0] dt_o,
  output logic [TW-1:0] bias_o,
  output logic [AW-1:0] tile_idx_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   stat_issued_o,
  output logic [31:0]   stat_stall_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [15:0]   seq_len_q, seq_len_d;
  logic [AW-1:0] tile_q, tile_d;
  logic [15:0]   token_q, token_d;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic [TW-1:0] dt_q, dt_d, bias_q, bias_d;
  logic [AW-1:0] tile_idx_q, tile_idx_d;

  logic [TW-1:0] bias_mem_q [NT];
  logic [TW-1:0] fifo_mem   [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, issue, last_tile, in_run;

  assign in_run     = (state_q == StRun);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign dt_ready_o = in_run && !fifo_full;
  assign push       = dt_valid_i && dt_ready_o;
  // The run leaves RUN on the final issue, so in RUN the issued count is always below the target.
  assign issue      = in_run && !fifo_empty && !hold_i;
  assign last_tile  = (token_q == seq_len_q - 16'd1) && (tile_q == AW'(NT - 1));

  // Bias table: written only while idle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NT); i++) bias_mem_q[i] <= '0;
    end else if (bias_we_i && !in_run && (32'(bias_addr_i) < NT)) begin
      bias_mem_q[bias_addr_i] <= bias_wdata_i;
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[PW-1:0]] <= dt_data_i;
  end

  // Next-state: run control, FIFO pointers, tile/token walk and output registers.
  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    tile_d     = tile_q;
    token_d    = token_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = valid_q && last_q;
    dt_d       = dt_q;
    bias_d     = bias_q;
    tile_idx_d = tile_idx_q;

    if (push) wptr_d = wptr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (seq_len_i != 16'd0) begin
            state_d   = StRun;
            seq_len_d = seq_len_i;
            tile_d    = '0;
            token_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          rptr_d     = rptr_q + 1'b1;
          valid_d    = 1'b1;
          dt_d       = fifo_mem[rptr_q[PW-1:0]];
          bias_d     = bias_mem_q[tile_q];
          tile_idx_d = tile_q;
          last_d     = last_tile;
          if (tile_q == AW'(NT - 1)) begin
            tile_d  = '0;
            token_d = token_q + 16'd1;
          end else begin
            tile_d = tile_q + 1'b1;
          end
          // Run end drops any surplus buffered tiles.
          if (last_tile) begin
            state_d = StIdle;
            wptr_d  = '0;
            rptr_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      seq_len_q  <= '0;
      tile_q     <= '0;
      token_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      dt_q       <= '0;
      bias_q     <= '0;
      tile_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      seq_len_q  <= seq_len_d;
      tile_q     <= tile_d;
      token_q    <= token_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      dt_q       <= dt_d;
      bias_q     <= bias_d;
      tile_idx_q <= tile_idx_d;
    end
  end

  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign done_o     = done_q;
  assign dt_o       = dt_q;
  assign bias_o     = bias_q;
  assign tile_idx_o = tile_idx_q;
  assign busy_o     = in_run;

`ifdef DT_FEED_STATS_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  // Saturating issue and stall counters, cleared when a run is started.
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (start_i && !in_run) begin
      issued_d = '0;
      stall_d  = '0;
    end else begin
      if (issue && (issued_q != '1)) issued_d = issued_q + 32'd1;
      if (in_run && !fifo_empty && hold_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stall_q;
`else
  assign stat_issued_o = '0;
  assign stat_stall_o  = '0;
`endif

endmodule

// File: tb/tb_dt_bias_feeder.sv
// Directed self-checking bench for dt_bias_feeder (default parameters).
module tb_dt_bias_feeder;

`ifdef DT_FEED_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] seq_len_i;
  logic        bias_we_i;
  logic [4:0]  bias_addr_i;
  logic [15:0] bias_wdata_i;
  logic        dt_valid_i;
  logic        dt_ready_o;
  logic [15:0] dt_data_i;
  logic        hold_i;
  logic        valid_o;
  logic [15:0] dt_o;
  logic [15:0] bias_o;
  logic [4:0]  tile_idx_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] stat_issued_o;
  logic [31:0] stat_stall_o;

  int n_checks = 0;
  int n_errors = 0;

  dt_bias_feeder u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .seq_len_i    (seq_len_i),
    .bias_we_i    (bias_we_i),
    .bias_addr_i  (bias_addr_i),
    .bias_wdata_i (bias_wdata_i),
    .dt_valid_i   (dt_valid_i),
    .dt_ready_o   (dt_ready_o),
    .dt_data_i    (dt_data_i),
    .hold_i       (hold_i),
    .valid_o      (valid_o),
    .dt_o         (dt_o),
    .bias_o       (bias_o),
    .tile_idx_o   (tile_idx_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stat_issued_o(stat_issued_o),
    .stat_stall_o (stat_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int seq_len);
    start_i   = 1'b1;
    seq_len_i = 16'(seq_len);
    tick();
    start_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(valid_o), 0);
    check({tag, "_last"},   32'(last_o), 0);
    check({tag, "_done"},   32'(done_o), 0);
    check({tag, "_busy"},   32'(busy_o), 0);
    check({tag, "_ready"},  32'(dt_ready_o), 0);
    check({tag, "_sti"},    stat_issued_o, 0);
    check({tag, "_sts"},    stat_stall_o, 0);
    check({tag, "_dt"},     32'(dt_o), 0);
    check({tag, "_bias"},   32'(bias_o), 0);
    check({tag, "_idx"},    32'(tile_idx_o), 0);
  endtask

  // Streams dt tiles (data 0x1000+n) into a started run and checks every issue.
  // pre tiles are assumed already buffered; abort_at >= 0 returns after that many issues.
  task automatic run_stream(input int seq_len, input int pre, input bit bias_on,
                            input bit poke, input int abort_at);
    int total, sent, got, first_c, last_c, done_c, n_last, n_done, wraps, prev_idx;
    bit acc;
    total = seq_len * 24;
    sent = pre; got = 0; first_c = -1; last_c = -1; done_c = -1;
    n_last = 0; n_done = 0; wraps = 0; prev_idx = -1;
    hold_i = 1'b0;
    for (int c = 0; c < total + 40; c++) begin
      dt_valid_i   = (sent < total);
      dt_data_i    = 16'h1000 + 16'(sent);
      bias_we_i    = poke && (sent < total);
      bias_addr_i  = 5'd5;
      bias_wdata_i = 16'hFFFF;
      acc = dt_valid_i && dt_ready_o;
      tick();
      if (acc) sent++;
      if (valid_o) begin
        check("iss_dt",   32'(dt_o), 32'(16'h1000 + 16'(got)));
        check("iss_idx",  32'(tile_idx_o), 32'(got % 24));
        check("iss_bias", 32'(bias_o), bias_on ? 32'(16'h3C00 + 16'(got % 24)) : 32'd0);
        check("iss_last", 32'(last_o), 32'(got == total - 1));
        if (prev_idx == 23 && tile_idx_o == 5'd0) wraps++;
        prev_idx = int'(tile_idx_o);
        if (first_c < 0) first_c = c;
        last_c = c;
        if (last_o) n_last++;
        got++;
        if (abort_at >= 0 && got == abort_at) return;
      end
      if (done_o) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    dt_valid_i = 1'b0;
    bias_we_i  = 1'b0;
    check("issues",     32'(got), 32'(total));
    check("done_delay", 32'(done_c), 32'(last_c + 1));
    check("n_done",     32'(n_done), 1);
    check("n_last",     32'(n_last), 1);
    check("b2b",        32'(last_c - first_c), 32'(total - 1));
    check("wraps",      32'(wraps), 32'(seq_len - 1));
    check("busy_end",   32'(busy_o), 0);
    if (pre == 0) check("latency", 32'(first_c), 1);
  endtask

  int  nacc, nvalid, stall_exp;
  bit  acc;

  initial begin
    rst = 1'b1; start_i = 1'b0; seq_len_i = '0; bias_we_i = 1'b0; bias_addr_i = '0;
    bias_wdata_i = '0; dt_valid_i = 1'b0; dt_data_i = '0; hold_i = 1'b0;
    #1;
    check_all_zero("rst");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Bias table load.
    for (int k = 0; k < 24; k++) begin
      bias_we_i = 1'b1; bias_addr_i = 5'(k); bias_wdata_i = 16'h3C00 + 16'(k);
      tick();
    end
    bias_we_i = 1'b0;

    // Single-token run with a RUN-time bias write to tile 5 that must be ignored.
    start_run(1);
    check("busy_run", 32'(busy_o), 1);
    run_stream(1, 0, 1'b1, 1'b1, -1);
    check("stat_iss", stat_issued_o, Stats ? 32'd24 : 32'd0);

    // Back-pressure: hold high, FIFO fills to 4 and nothing is issued.
    start_run(1);
    hold_i = 1'b1; dt_valid_i = 1'b1; nacc = 0; nvalid = 0; stall_exp = 0;
    for (int c = 0; c < 10; c++) begin
      dt_data_i = 16'h1000 + 16'(nacc);
      if (nacc > 0) stall_exp++;
      acc = dt_ready_o;
      tick();
      if (acc) nacc++;
      if (valid_o) nvalid++;
    end
    check("hold_acc",   32'(nacc), 4);
    check("hold_valid", 32'(nvalid), 0);
    check("hold_ready", 32'(dt_ready_o), 0);
    check("hold_stall", stat_stall_o, Stats ? 32'(stall_exp) : 32'd0);
    run_stream(1, 4, 1'b1, 1'b0, -1);
    check("stat_stall_end", stat_stall_o, Stats ? 32'(stall_exp) : 32'd0);

    // Three tokens: two index wraps, one last and one done.
    start_run(3);
    run_stream(3, 0, 1'b1, 1'b0, -1);

    // Zero-length run.
    start_run(0);
    check("z_done",  32'(done_o), 1);
    check("z_busy",  32'(busy_o), 0);
    check("z_ready", 32'(dt_ready_o), 0);
    tick();
    check("z_done2", 32'(done_o), 0);
    check("z_busy2", 32'(busy_o), 0);

    // Asynchronous reset in the middle of a run.
    start_run(1);
    run_stream(1, 0, 1'b1, 1'b0, 10);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    dt_valid_i = 1'b0;
    tick();
    check("mid_rst_done", 32'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy_o), 0);
    start_run(1);
    run_stream(1, 0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
